alu_arbiter: RTL

Round-robin arbiter and sequencer that shares the single 16-bit ALU between up to NREQ requesters (fetch/PC incrementer, main datapath, branch comparator, debug port). Each requester presents operands and a 3-bit ALU control code over a valid/ready handshake. The block grants one requester, drives the ALU for one execute cycle, and returns the registered result and zero flag to the granted requester over a valid/ready response channel.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_arbiter_if.sv | 39 +++
 rtl/alu_arbiter_rr_picker.sv | 31 +++
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and FSM encoding for the ALU arbiter.
// Opcodes follow the external ALU's 3-bit control encoding.
package alu_pkg;

   localparam int DEFAULT_WIDTH = 16;

   localparam logic [2:0] ALU_AND = 3'd0;
   localparam logic [2:0] ALU_OR  = 3'd1;
   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd3;
   localparam logic [2:0] ALU_SLL = 3'd4;
   localparam logic [2:0] ALU_SRL = 3'd5;
   localparam logic [2:0] ALU_SRA = 3'd6;
   localparam logic [2:0] ALU_SLT = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and ALU-side signals of alu_arbiter, plus FSM debug view.
// Handshake: a transfer happens on the rising clock edge where valid[i] and ready[i] are both high.
interface alu_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
);
   localparam int PTR_W = $clog2(NREQ);

   logic [NREQ-1:0]       reqValid;
   logic [NREQ-1:0]       reqReady;
   logic [NREQ*WIDTH-1:0] reqIn1;
   logic [NREQ*WIDTH-1:0] reqIn2;
   logic [NREQ*3-1:0]     reqOp;
   logic [NREQ-1:0]       reqLock;
   logic [NREQ-1:0]       rspValid;
   logic [NREQ-1:0]       rspReady;
   logic [WIDTH-1:0]      rspResult;
   logic                  rspZero;
   logic [WIDTH-1:0]      aluIn1;
   logic [WIDTH-1:0]      aluIn2;
   logic [2:0]            aluControl;
   logic [WIDTH-1:0]      aluResult;
   logic                  aluIsZero;
   alu_pkg::state_e       dbg_state;
   logic [PTR_W-1:0]      dbg_ptr;

   modport slave (
      input  reqValid, reqIn1, reqIn2, reqOp, reqLock, rspReady, aluResult, aluIsZero,
      output reqReady, rspValid, rspResult, rspZero, aluIn1, aluIn2, aluControl,
             dbg_state, dbg_ptr
   );

   modport master (
      output reqValid, reqIn1, reqIn2, reqOp, reqLock, rspReady, aluResult, aluIsZero,
      input  reqReady, rspValid, rspResult, rspZero, aluIn1, aluIn2, aluControl,
             dbg_state, dbg_ptr
   );

endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// rr_picker: combinational rotate-priority selector; first set bit at or above ptr, wrapping.
// Produces both a one-hot grant and its binary index.
module rr_picker #(
   parameter int NREQ  = 4,
   parameter int PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   logic [PTR_W-1:0] sel;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      sel   = '0;
      for (int k = 0; k < NREQ; k++) begin
         sel = PTR_W'((int'(ptr) + k) % NREQ);
         if (!any && req[sel]) begin
            any        = 1'b1;
            idx        = sel;
            grant[sel] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU among NREQ requesters, IDLE -> EXEC -> RESP per op.
// Optional macro ALU_ARB_LOCK_EN: reqLock keeps the grant on one requester across several ops.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic          clock,
   input logic          resetN,
   alu_arbiter_if.slave bus
);

   localparam int PTR_W = $clog2(NREQ);

   state_e           state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] g_q, g_d;
   logic [WIDTH-1:0] in1_q, in1_d;
   logic [WIDTH-1:0] in2_q, in2_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;

   logic [NREQ-1:0]  eligible;
   logic [NREQ-1:0]  pick_grant;
   logic [PTR_W-1:0] pick_idx;
   logic             pick_any;
   logic [NREQ-1:0]  g_onehot;
   logic [PTR_W-1:0] next_ptr;

   always_comb begin
      g_onehot      = '0;
      g_onehot[g_q] = 1'b1;
   end

   assign next_ptr = (g_q == PTR_W'(NREQ - 1)) ? '0 : g_q + 1'b1;

`ifdef ALU_ARB_LOCK_EN
   logic lock_q, lock_d;
   // While locked only the holder may win; ptr already points at it.
   assign eligible = lock_q ? (bus.reqValid & g_onehot) : bus.reqValid;
`else
   logic unused_lock;
   assign unused_lock = ^bus.reqLock;
   assign eligible    = bus.reqValid;
`endif

   rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_picker (
      .req   (eligible),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      g_d      = g_q;
      in1_d    = in1_q;
      in2_d    = in2_q;
      op_d     = op_q;
      result_d = result_q;
      zero_d   = zero_q;
`ifdef ALU_ARB_LOCK_EN
      lock_d   = lock_q;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef ALU_ARB_LOCK_EN
            if (lock_q && !bus.reqLock[g_q]) lock_d = 1'b0;
`endif
            if (pick_any) begin
               in1_d   = bus.reqIn1[int'(pick_idx)*WIDTH +: WIDTH];
               in2_d   = bus.reqIn2[int'(pick_idx)*WIDTH +: WIDTH];
               op_d    = bus.reqOp[int'(pick_idx)*3 +: 3];
               g_d     = pick_idx;
               state_d = ST_EXEC;
`ifdef ALU_ARB_LOCK_EN
               lock_d  = bus.reqLock[pick_idx];
`endif
            end
         end
         ST_EXEC: begin
            result_d = bus.aluResult;
            zero_d   = bus.aluIsZero;
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rspReady[g_q]) begin
               state_d = ST_IDLE;
               ptr_d   = next_ptr;
`ifdef ALU_ARB_LOCK_EN
               if (lock_q) ptr_d = g_q;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         g_q      <= '0;
         in1_q    <= '0;
         in2_q    <= '0;
         op_q     <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         g_q      <= g_d;
         in1_q    <= in1_d;
         in2_q    <= in2_d;
         op_q     <= op_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

`ifdef ALU_ARB_LOCK_EN
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) lock_q <= 1'b0;
      else         lock_q <= lock_d;
   end
`endif

   // reqReady is gated by resetN so it reads zero while reset is held.
   assign bus.reqReady   = (state_q == ST_IDLE && resetN) ? pick_grant : '0;
   assign bus.rspValid   = (state_q == ST_RESP) ? g_onehot : '0;
   assign bus.rspResult  = result_q;
   assign bus.rspZero    = zero_q;
   assign bus.aluIn1     = in1_q;
   assign bus.aluIn2     = in2_q;
   assign bus.aluControl = op_q;
   assign bus.dbg_state  = state_q;
   assign bus.dbg_ptr    = ptr_q;

endmodule
